seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

- Serial pattern transmitter: the transmit-side counterpart of the team's serial sequence detector.
- Shifts out a programmable 1–8 bit pattern, MSB-first, on a single-bit line.
- Each bit is held for a programmable number of clocks; supports one-shot or continuous repeat.
- Sits in front of the detector input on the Tiny Tapeout tile, and drives a 7-segment digit showing bits remaining.

## Interface
Parameters:
- DIV_W, 8, width of the bit-period divider input.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous active-low reset; 0 = reset on next rising edge.
- start  input  1  request transmission; sampled only in IDLE.
- abort  input  1  stop transmission; return to IDLE on next edge.
- pattern  input  8  bits to send; captured at accepted start.
- len  input  3  pattern length minus one (0 = 1 bit, 7 = 8 bits); captured at start.
- repeat  input  1  1 = loop pattern continuously; captured at start.
- div  input  DIV_W  bit period = div+1 clocks; captured at start.
- tx_bit  output  1  serial line; idles high.
- tx_valid  output  1  high while a pattern bit is driven.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse after the last bit of a non-repeating pattern.
- seg  output  8  7-segment drive: seg[6:0] = gfedcba, seg[7] = dp.

## Operation
- States: IDLE, SEND.
- IDLE → SEND: start=1 and abort=0.
  - Captures pattern, len, repeat, div.
  - Sets bit index idx=len and period counter cnt=0.
- SEND:
  - tx_bit = captured pattern[idx]; tx_valid=1; busy=1.
  - cnt increments each clock. When cnt==div: cnt←0, then:
    - idx>0: idx←idx-1.
    - idx==0 and repeat=1: idx←len, no gap, no done.
    - idx==0 and repeat=0: go to IDLE, done=1 for one cycle.
- abort=1 in SEND: IDLE on next edge, no done pulse; abort beats any bit/period event in the same cycle.
- start while busy: ignored; inputs are not re-captured.
- start and abort both high in IDLE: abort wins, stay IDLE.
- Idle high line keeps the downstream detector parked in its initial state.
- Arithmetic:
  - cnt is DIV_W bits, compared for equality only; div=0 gives a one-clock bit period.
  - Bits remaining = idx+1 (range 1..8).
- Reset values (reset=0 at an edge, any state, including mid-pattern):
  - State IDLE, tx_bit=1, tx_valid=0, busy=0, done=0, idx=0, cnt=0.
  - seg=0x40 if SEQ_TX_SEG_EN is defined, else 0x00.

## Timing
- All outputs are registered.
- Start accepted at edge E0: first bit appears on tx_bit in the cycle after E0, held div+1 cycles.
- Bit k (0-based from MSB) occupies cycles E0+1+k(div+1) through E0+(k+1)(div+1).
- One-shot latency: done is high in cycle E0+(len+1)(div+1)+1. In that cycle tx_bit=1, tx_valid=0, busy=0.
- A start in the done cycle is accepted, giving back-to-back patterns with one idle-high cycle between them.
- Repeat mode: the last bit of one pass is immediately followed by the first bit of the next.

## Configuration
- Macro: SEQ_TX_SEG_EN.
- Defined:
  - seg shows bits remaining (idx+1) as a digit, dp lit while busy.
  - Digit encodings: 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F; set seg[7] in SEND.
  - seg=0x40 ("-") in IDLE.
  - seg is registered and updates with idx.
- Undefined: seg tied to 0x00; no segment decode logic synthesized.

## Test plan
- Basic pattern: reset=0 for 2 clocks, then pattern=0x03, len=2, div=0, repeat=0, start pulse.
  - tx_bit = 0,1,1 in cycles E0+1..E0+3.
  - Cycle E0+4: done=1, tx_bit=1, busy=0.
- Divider: pattern=0xA5, len=7, div=2.
  - Each bit held 3 cycles: sequence 1,0,1,0,0,1,0,1.
  - done at E0+25.
- Repeat and abort: pattern=0x03, len=2, div=0, repeat=1.
  - Sequence 0,1,1,0,1,1,… with no done.
  - abort after 7 bits → next cycle busy=0, tx_bit=1, done stays 0.
- Edge cases:
  - start during SEND with a different pattern → ignored, original completes.
  - start+abort together in IDLE → stays IDLE.
  - start in the done cycle → new pattern begins next cycle.
- Reset mid-pattern: reset=0 during bit 2 → next edge tx_bit=1, busy=0, tx_valid=0, seg=0x40 (SEQ_TX_SEG_EN defined).
- Segment display (SEQ_TX_SEG_EN defined): len=3, div=0.
  - seg = 0xE6, 0xCF, 0xDB, 0x86 over the four bits.
  - seg=0x40 afterwards.
  - Macro undefined: seg=0x00 always.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. Sends a 1..8 bit pattern
// MSB-first. Each bit is held for div+1 clocks. Supports one-shot or
// continuous repeat. The line idles high.
// Optional feature macro: SEQ_TX_SEG_EN. When it is defined, a registered
// 7-segment digit shows the bits remaining. When it is undefined, seg is 0.
// The "repeat" port is named repeat_mode because repeat is a reserved word.
module seq_pattern_tx #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       pattern,
   input  logic [2:0]       len,
   input  logic             repeat_mode,
   input  logic [DIV_W-1:0] div,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             busy,
   output logic             done,
   output logic [7:0]       seg
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]       state, state_n;
   logic [7:0]       pat_q;
   logic [2:0]       len_q;
   logic             rep_q;
   logic [DIV_W-1:0] div_q;
   logic [2:0]       idx, idx_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic             load, fin, bit_n;

   // next-state: accept start, advance period counter and bit index, abort wins
   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      load    = 1'b0;
      fin     = 1'b0;
      if (state == S_IDLE) begin
         if (start && !abort) begin
            load    = 1'b1;
            state_n = S_SEND;
            idx_n   = len;
            cnt_n   = '0;
         end
      end else if (abort) begin
         state_n = S_IDLE;
         idx_n   = 3'd0;
         cnt_n   = '0;
      end else if (cnt == div_q) begin
         cnt_n = '0;
         if (idx != 3'd0) begin
            idx_n = idx - 3'd1;
         end else if (rep_q) begin
            idx_n = len_q;
         end else begin
            state_n = S_IDLE;
            fin     = 1'b1;
         end
      end else begin
         cnt_n = cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   // The outputs are registered from next-state, so the first bit appears
   // in the cycle right after start is accepted.
   always_comb begin
      bit_n = load ? pattern[idx_n] : pat_q[idx_n];
   end

   // state, captured configuration and registered line outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         pat_q    <= 8'h00;
         len_q    <= 3'd0;
         rep_q    <= 1'b0;
         div_q    <= '0;
         idx      <= 3'd0;
         cnt      <= '0;
         tx_bit   <= 1'b1;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
         if (load) begin
            pat_q <= pattern;
            len_q <= len;
            rep_q <= repeat_mode;
            div_q <= div;
         end
         tx_bit   <= (state_n == S_SEND) ? bit_n : 1'b1;
         tx_valid <= (state_n == S_SEND);
         busy     <= (state_n == S_SEND);
         done     <= fin;
      end
   end

`ifdef SEQ_TX_SEG_EN
   // bits remaining (index+1) to gfedcba digit code
   function automatic logic [6:0] digit(input logic [2:0] i);
      case (i)
         3'd0:    digit = 7'h06;
         3'd1:    digit = 7'h5B;
         3'd2:    digit = 7'h4F;
         3'd3:    digit = 7'h66;
         3'd4:    digit = 7'h6D;
         3'd5:    digit = 7'h7D;
         3'd6:    digit = 7'h07;
         default: digit = 7'h7F;
      endcase
   endfunction

   // segment register tracks the next index; dp lit while sending, "-" when idle
   always_ff @(posedge clk) begin
      if (!reset) begin
         seg <= 8'h40;
      end else begin
         seg <= (state_n == S_SEND) ? {1'b1, digit(idx_n)} : 8'h40;
      end
   end
`else
   assign seg = 8'h00;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx. On each accepted start, a reference model
// queues the expected output for every future cycle. Each cycle one check
// compares the DUT against that queue. Literal checks pin the directed cases.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       reset, start, abort, repeat_mode;
   logic [7:0] pattern;
   logic [2:0] len;
   logic [7:0] div;
   logic       tx_bit, tx_valid, busy, done;
   logic [7:0] seg;

   seq_pattern_tx #(.DIV_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .pattern(pattern), .len(len), .repeat_mode(repeat_mode), .div(div),
      .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done), .seg(seg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       done;
      logic       busy;
      logic       vld;
      logic       bitv;
      logic [7:0] seg;
   } obs_t;

`ifdef SEQ_TX_SEG_EN
   localparam logic [7:0] IDLE_SEG = 8'h40;
`else
   localparam logic [7:0] IDLE_SEG = 8'h00;
`endif
   localparam obs_t IDLE_E = '{done: 1'b0, busy: 1'b0, vld: 1'b0, bitv: 1'b1, seg: IDLE_SEG};

   int   n_vec = 0;
   int   n_bad = 0;
   obs_t cur;
   obs_t q[$];
   logic [7:0] m_pat;
   logic [2:0] m_len;
   logic       m_rep;
   logic [7:0] m_div;

   function automatic logic [7:0] seg_for(input int remaining);
      logic [7:0] tbl [1:8];
      tbl = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
`ifdef SEQ_TX_SEG_EN
      return tbl[remaining] | 8'h80;
`else
      return 8'h00;
`endif
   endfunction

   // one full pass: each bit held div+1 cycles, then a done cycle if one-shot
   task automatic push_pass();
      for (int k = 0; k <= int'(m_len); k++)
         for (int r = 0; r <= int'(m_div); r++)
            q.push_back('{done: 1'b0, busy: 1'b1, vld: 1'b1,
                          bitv: m_pat[int'(m_len) - k],
                          seg: seg_for(int'(m_len) - k + 1)});
      if (!m_rep) q.push_back('{done: 1'b1, busy: 1'b0, vld: 1'b0, bitv: 1'b1, seg: IDLE_SEG});
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // apply inputs for one cycle, advance the model, compare #1 after the edge
   task automatic step(input logic st, input logic ab, input logic rs);
      obs_t act;
      start = st; abort = ab; reset = rs;
      @(posedge clk);
      if (!rs) begin
         q.delete();
         cur = IDLE_E;
      end else if (cur.busy) begin
         if (ab) begin
            q.delete();
            cur = IDLE_E;
         end else begin
            if (q.size() == 0) push_pass();
            cur = q.pop_front();
         end
      end else if (st && !ab) begin
         m_pat = pattern; m_len = len; m_rep = repeat_mode; m_div = div;
         q.delete();
         push_pass();
         cur = q.pop_front();
      end else begin
         cur = IDLE_E;
      end
      #1;
      act = '{done: done, busy: busy, vld: tx_valid, bitv: tx_bit, seg: seg};
      chk("model", 12'(act), 12'(cur));
      start = 1'b0; abort = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] p, input logic [2:0] l, input logic [7:0] d, input logic r);
      pattern = p; len = l; div = d; repeat_mode = r;
   endtask

   initial begin
      logic [7:0] seq_a5 [0:7];
      logic [7:0] seg_exp [0:3];
      seq_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
`ifdef SEQ_TX_SEG_EN
      seg_exp = '{8'hE6, 8'hCF, 8'hDB, 8'h86};
`else
      seg_exp = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
      cur = IDLE_E;
      start = 0; abort = 0; reset = 0;
      cfg(8'h00, 3'd0, 8'd0, 1'b0);

      // reset state
      step(0, 0, 0);
      step(0, 0, 0);
      chk("rst_line", {busy, tx_valid, tx_bit, done}, 4'b0010);
      chk("rst_seg", seg, IDLE_SEG);

      // basic pattern 0x03, len 2
      cfg(8'h03, 3'd2, 8'd0, 1'b0);
      step(1, 0, 1);
      chk("basic_b0", tx_bit, 0);
      step(0, 0, 1); chk("basic_b1", tx_bit, 1);
      step(0, 0, 1); chk("basic_b2", tx_bit, 1);
      step(0, 0, 1); chk("basic_done", {done, tx_bit, busy}, 3'b110);

      // divider: 0xA5, 8 bits, 3 clocks per bit, done at E0+25
      cfg(8'hA5, 3'd7, 8'd2, 1'b0);
      step(1, 0, 1);
      for (int k = 0; k < 8; k++)
         for (int r = 0; r < 3; r++) begin
            if (!(k == 0 && r == 0)) step(0, 0, 1);
            chk("div_bit", tx_bit, seq_a5[k][0]);
         end
      step(0, 0, 1);
      chk("div_done", {done, busy}, 2'b10);

      // repeat then abort after 7 bits
      cfg(8'h03, 3'd2, 8'd0, 1'b1);
      step(1, 0, 1);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step(0, 0, 1);
         chk("rep_bit", {tx_bit, done}, {(i % 3 != 0), 1'b0});
      end
      step(0, 1, 1);
      chk("abort", {busy, tx_bit, done}, 3'b010);

      // start during SEND is ignored; original one-shot finishes at E0+4
      cfg(8'h03, 3'd2, 8'd0, 1'b0);
      step(1, 0, 1);
      cfg(8'hFF, 3'd7, 8'd5, 1'b1);
      step(1, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      chk("ignore_done", {done, busy}, 2'b10);

      // start and abort together in IDLE
      step(1, 1, 1);
      chk("sa_idle", {busy, tx_valid}, 2'b00);

      // start in the done cycle gives back-to-back patterns
      cfg(8'h03, 3'd2, 8'd0, 1'b0);
      step(1, 0, 1);
      step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
      chk("b2b_done", done, 1);
      step(1, 0, 1);
      chk("b2b_start", {tx_valid, tx_bit, busy}, 3'b101);
      step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);

      // reset during bit 2
      cfg(8'hA5, 3'd7, 8'd0, 1'b0);
      step(1, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("rst_mid", {tx_bit, busy, tx_valid}, 3'b100);
      chk("rst_mid_seg", seg, IDLE_SEG);

      // segment digits for a 4-bit pattern
      cfg(8'h0F, 3'd3, 8'd0, 1'b0);
      step(1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step(0, 0, 1);
         chk("seg_digit", seg, seg_exp[i]);
      end
      step(0, 0, 1);
      chk("seg_after", seg, IDLE_SEG);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cfg(8'($urandom), 3'($urandom), 8'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
         step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 59) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
